// File: rtl/sysinfo_pkg.sv
// Shared constants and types for the system identification register block.
// Imported by the read pipeline and the top-level register file.
package sysinfo_pkg;

    localparam logic [3:0] ADDR_SYSTEM_ID = 4'd0;
    localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
    localparam logic [3:0] ADDR_UPTIME_LO = 4'd2;
    localparam logic [3:0] ADDR_UPTIME_HI = 4'd3;
    localparam logic [3:0] ADDR_SCRATCH   = 4'd4;
    localparam logic [3:0] ADDR_CTRL      = 4'd5;
    localparam logic [3:0] ADDR_INFO      = 4'd6;
    localparam logic [3:0] ADDR_RESERVED  = 4'd7;
    localparam logic [3:0] ADDR_USER_BASE = 4'd8;

    localparam logic [15:0] VERSION = 16'h0002;

    localparam int CTRL_CLEAR_BIT  = 0;
    localparam int CTRL_FREEZE_BIT = 1;

    localparam int MAX_USER_WORDS = 8;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } rd_beat_t;

    function automatic logic [31:0] apply_be(
        logic [31:0] cur,
        logic [31:0] wd,
        logic [3:0]  be
    );
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sysinfo_rd_pipe.sv
// Fixed-depth read response pipeline; each accepted read yields exactly
// one beat DEPTH cycles later, and reset flushes all beats in flight.
import sysinfo_pkg::*;

module sysinfo_rd_pipe #(
    parameter int DEPTH = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  rd_beat_t    beat_in,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    rd_beat_t stage [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= beat_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign readdata      = stage[DEPTH-1].data;
    assign readdatavalid = stage[DEPTH-1].valid;

endmodule

// File: rtl/system_info_regs.sv
// Avalon-MM system ID block: constants, 64-bit uptime with LO/HI snapshot,
// scratch and control registers behind a pipelined read path.
import sysinfo_pkg::*;

module system_info_regs #(
    parameter logic [31:0]  SYSTEM_ID      = 32'h00000000,
    parameter logic [31:0]  TIMESTAMP      = 32'h00000000,
    parameter int           NUM_USER_WORDS = 0,
    parameter logic [255:0] USER_WORDS     = 256'h0,
    parameter int           READ_LATENCY   = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam int N_USER = (NUM_USER_WORDS > MAX_USER_WORDS) ?
                            MAX_USER_WORDS : NUM_USER_WORDS;

    logic        rd_en;
    logic        wr_en;
    logic        ctrl_wr;
    logic        clear_pulse;
    logic [63:0] uptime;
    logic [31:0] hi_snap;
    logic [31:0] scratch;
    logic        freeze;
    logic [31:0] rd_mux;
    logic [31:0] info_word;
    logic [31:0] user_word;
    logic [2:0]  user_idx;
    rd_beat_t    beat;

    // A simultaneous read wins; the write in that cycle is dropped.
    assign rd_en       = chipselect & read;
    assign wr_en       = chipselect & write & ~read;
    assign ctrl_wr     = wr_en & (address == ADDR_CTRL) & byteenable[0];
    assign clear_pulse = ctrl_wr & writedata[CTRL_CLEAR_BIT];

    assign user_idx  = address[2:0];
    assign user_word = (int'(user_idx) < N_USER) ?
                       USER_WORDS[{user_idx, 5'd0} +: 32] : 32'h0;
    assign info_word = {VERSION, 8'(READ_LATENCY), 8'(N_USER)};

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            (address == ADDR_SYSTEM_ID): rd_mux = SYSTEM_ID;
            (address == ADDR_TIMESTAMP): rd_mux = TIMESTAMP;
            (address == ADDR_UPTIME_LO): rd_mux = uptime[31:0];
            (address == ADDR_UPTIME_HI): rd_mux = hi_snap;
            (address == ADDR_SCRATCH):   rd_mux = scratch;
            (address == ADDR_CTRL):      rd_mux = {30'b0, freeze, 1'b0};
            (address == ADDR_INFO):      rd_mux = info_word;
            (address == ADDR_RESERVED):  rd_mux = '0;
            (address >= ADDR_USER_BASE): rd_mux = user_word;
            default:                     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uptime  <= '0;
            hi_snap <= '0;
            scratch <= '0;
            freeze  <= 1'b0;
        end else begin
            if (clear_pulse) begin
                uptime <= '0;
            end else if (!freeze) begin
                uptime <= uptime + 64'd1;
            end
            if (rd_en && (address == ADDR_UPTIME_LO)) begin
                hi_snap <= uptime[63:32];
            end
            if (wr_en && (address == ADDR_SCRATCH)) begin
                scratch <= apply_be(scratch, writedata, byteenable);
            end
            if (ctrl_wr) begin
                freeze <= writedata[CTRL_FREEZE_BIT];
            end
        end
    end

    // Idle beats carry zero data so readdata is 0 whenever not valid.
    assign beat.valid = rd_en;
    assign beat.data  = rd_en ? rd_mux : 32'h0;

    sysinfo_rd_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_rd_pipe (
        .clock        (clock),
        .reset_n      (reset_n),
        .beat_in      (beat),
        .readdata     (readdata),
        .readdatavalid(readdatavalid)
    );

endmodule

// File: tb/tb_system_info_regs.sv
// Self-checking bench: two instances (read latency 2 and 3) share one bus
// and are compared against a transaction-level model of the register map.
module tb_system_info_regs;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] cyc;
    } resp_t;

    localparam logic [31:0] SYSID [2] = '{32'h56E2_F0A3, 32'hC0FF_EE01};
    localparam int          LAT   [2] = '{2, 3};
    localparam logic [31:0] TS        = 32'h6650_1A2B;
    localparam int          NUSER     = 3;
    localparam logic [31:0] UW [8] = '{
        32'hA5A5_0000, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003,
        32'h4444_0004, 32'h5555_0005, 32'h6666_0006, 32'h7777_0007
    };
    localparam logic [255:0] USER = {UW[7], UW[6], UW[5], UW[4],
                                     UW[3], UW[2], UW[1], UW[0]};

    logic        clock;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] rdata [2];
    logic        rvalid [2];

    logic [31:0] cyc;
    int          compared;
    int          failed;
    int          stray;

    logic [63:0] m_up;
    logic [31:0] m_hi;
    logic [31:0] m_scr;
    logic        m_frz;

    resp_t exp_q [2][$];
    resp_t obs_q [2][$];

    system_info_regs #(
        .SYSTEM_ID(SYSID[0]), .TIMESTAMP(TS), .NUM_USER_WORDS(NUSER),
        .USER_WORDS(USER), .READ_LATENCY(LAT[0])
    ) u_a (
        .clock(clock), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(rdata[0]), .readdatavalid(rvalid[0])
    );

    system_info_regs #(
        .SYSTEM_ID(SYSID[1]), .TIMESTAMP(TS), .NUM_USER_WORDS(NUSER),
        .USER_WORDS(USER), .READ_LATENCY(LAT[1])
    ) u_b (
        .clock(clock), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(rdata[1]), .readdatavalid(rvalid[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial cyc = '0;
    always @(posedge clock) cyc <= cyc + 32'd1;

    function automatic logic [31:0] exp_read(int d, logic [3:0] a);
        if (a >= 4'd8) return (int'(a) - 8 < NUSER) ? UW[a[2:0]] : 32'h0;
        case (a)
            4'd0:    return SYSID[d];
            4'd1:    return TS;
            4'd2:    return m_up[31:0];
            4'd3:    return m_hi;
            4'd4:    return m_scr;
            4'd5:    return {30'b0, m_frz, 1'b0};
            4'd6:    return {16'h0002, 8'(LAT[d]), 8'(NUSER)};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_up = '0; m_hi = '0; m_scr = '0; m_frz = 1'b0;
    endtask

    // Advance the model across the clock edge that ends the current cycle.
    task automatic model_step();
        logic rd, wr, frz_n;
        rd = chipselect && read;
        wr = chipselect && write && !read;
        frz_n = m_frz;
        if (rd && address == 4'd2) m_hi = m_up[63:32];
        if (wr && address == 4'd4) begin
            for (int b = 0; b < 4; b++)
                if (byteenable[b]) m_scr[8*b +: 8] = writedata[8*b +: 8];
        end
        if (wr && address == 4'd5 && byteenable[0]) frz_n = writedata[1];
        if (wr && address == 4'd5 && byteenable[0] && writedata[0]) m_up = '0;
        else if (!m_frz) m_up = m_up + 64'd1;
        m_frz = frz_n;
    endtask

    task automatic bus_cycle(input logic cs, input logic rd, input logic wr,
                             input logic [3:0] a, input logic [31:0] wd,
                             input logic [3:0] be);
        @(posedge clock);
        #1;
        chipselect = cs; read = rd; write = wr;
        address = a; writedata = wd; byteenable = be;
        if (cs && rd) begin
            for (int d = 0; d < 2; d++)
                exp_q[d].push_back('{data: exp_read(d, a), cyc: cyc + 32'(LAT[d])});
        end
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            if (rvalid[d]) obs_q[d].push_back('{data: rdata[d], cyc: cyc});
            else if (rdata[d] != 32'h0) stray++;
        end
        model_step();
    endtask

    task automatic idle(input int n);
        repeat (n) bus_cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        chipselect = 0; read = 0; write = 0;
        address = 0; writedata = 0; byteenable = 0;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            compared++;
            if (rvalid[d] !== 1'b0) begin
                failed++;
                $display("FAIL reset_valid dut%0d got %b want 0", d, rvalid[d]);
            end
            compared++;
            if (rdata[d] !== 32'h0) begin
                failed++;
                $display("FAIL reset_data dut%0d got %h want 0", d, rdata[d]);
            end
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_step();
    endtask

    task automatic test_id_back_to_back();
        bus_cycle(1, 1, 0, 4'd0, 0, 0);
        bus_cycle(1, 1, 0, 4'd1, 0, 0);
        bus_cycle(1, 1, 0, 4'd6, 0, 0);
        bus_cycle(1, 1, 0, 4'd3, 0, 0);
        bus_cycle(1, 1, 0, 4'd7, 0, 0);
        idle(5);
        for (int d = 0; d < 2; d++) begin
            compared++;
            if (obs_q[d].size() != exp_q[d].size()) begin
                failed++;
                $display("FAIL id_count dut%0d got %0d want %0d", d, obs_q[d].size(), exp_q[d].size());
            end
            for (int i = 0; i < exp_q[d].size() && i < obs_q[d].size(); i++) begin
                compared++;
                if (obs_q[d][i] !== exp_q[d][i]) begin
                    failed++;
                    $display("FAIL id_resp dut%0d #%0d got %h@%0d want %h@%0d", d, i,
                             obs_q[d][i].data, obs_q[d][i].cyc, exp_q[d][i].data, exp_q[d][i].cyc);
                end
            end
        end
        compared++;
        if (obs_q[0].size() < 3 || obs_q[0][2].data !== 32'h0002_0203) begin
            failed++;
            $display("FAIL id_info got %h want 00020203", obs_q[0].size() > 2 ? obs_q[0][2].data : 32'hx);
        end
        for (int d = 0; d < 2; d++) begin exp_q[d].delete(); obs_q[d].delete(); end
    endtask

    task automatic test_scratch();
        bus_cycle(1, 0, 1, 4'd4, 32'hDEADBEEF, 4'b0101);
        bus_cycle(1, 1, 0, 4'd4, 0, 0);
        bus_cycle(1, 1, 1, 4'd4, 32'h1111_2222, 4'hF);
        bus_cycle(1, 1, 0, 4'd4, 0, 0);
        bus_cycle(0, 0, 1, 4'd4, 32'h9999_9999, 4'hF);
        bus_cycle(1, 0, 1, 4'd0, 32'h9999_9999, 4'hF);
        bus_cycle(1, 1, 0, 4'd4, 0, 0);
        bus_cycle(1, 0, 1, 4'd4, 32'hCAFE_F00D, 4'b1010);
        bus_cycle(1, 1, 0, 4'd4, 0, 0);
        idle(5);
        for (int d = 0; d < 2; d++) begin
            compared++;
            if (obs_q[d].size() != exp_q[d].size()) begin
                failed++;
                $display("FAIL scratch_count dut%0d got %0d want %0d", d, obs_q[d].size(), exp_q[d].size());
            end
            for (int i = 0; i < exp_q[d].size() && i < obs_q[d].size(); i++) begin
                compared++;
                if (obs_q[d][i] !== exp_q[d][i]) begin
                    failed++;
                    $display("FAIL scratch_resp dut%0d #%0d got %h@%0d want %h@%0d", d, i,
                             obs_q[d][i].data, obs_q[d][i].cyc, exp_q[d][i].data, exp_q[d][i].cyc);
                end
            end
        end
        compared++;
        if (obs_q[0].size() < 3 || obs_q[0][0].data !== 32'h00AD00EF
            || obs_q[0][2].data !== 32'h00AD00EF) begin
            failed++;
            $display("FAIL scratch_be got %h/%h want 00AD00EF",
                     obs_q[0].size() > 0 ? obs_q[0][0].data : 32'hx,
                     obs_q[0].size() > 2 ? obs_q[0][2].data : 32'hx);
        end
        for (int d = 0; d < 2; d++) begin exp_q[d].delete(); obs_q[d].delete(); end
    endtask

    task automatic test_uptime_snapshot();
        @(posedge clock);
        #1;
        force u_a.uptime = 64'h1_FFFF_FFFE;
        force u_b.uptime = 64'h1_FFFF_FFFE;
        m_up = 64'h1_FFFF_FFFE;
        #1;
        release u_a.uptime;
        release u_b.uptime;
        model_step();
        bus_cycle(1, 1, 0, 4'd2, 0, 0);
        idle(10);
        bus_cycle(1, 1, 0, 4'd3, 0, 0);
        bus_cycle(1, 1, 0, 4'd2, 0, 0);
        bus_cycle(1, 1, 0, 4'd3, 0, 0);
        idle(5);
        for (int d = 0; d < 2; d++) begin
            compared++;
            if (obs_q[d].size() != exp_q[d].size()) begin
                failed++;
                $display("FAIL snap_count dut%0d got %0d want %0d", d, obs_q[d].size(), exp_q[d].size());
            end
            for (int i = 0; i < exp_q[d].size() && i < obs_q[d].size(); i++) begin
                compared++;
                if (obs_q[d][i] !== exp_q[d][i]) begin
                    failed++;
                    $display("FAIL snap_resp dut%0d #%0d got %h@%0d want %h@%0d", d, i,
                             obs_q[d][i].data, obs_q[d][i].cyc, exp_q[d][i].data, exp_q[d][i].cyc);
                end
            end
        end
        compared++;
        if (obs_q[0].size() < 4 || obs_q[0][0].data !== 32'hFFFF_FFFF
            || obs_q[0][1].data !== 32'h1 || obs_q[0][3].data !== 32'h2) begin
            failed++;
            $display("FAIL snap_hi got lo=%h hi=%h hi2=%h want FFFFFFFF/1/2",
                     obs_q[0].size() > 0 ? obs_q[0][0].data : 32'hx,
                     obs_q[0].size() > 1 ? obs_q[0][1].data : 32'hx,
                     obs_q[0].size() > 3 ? obs_q[0][3].data : 32'hx);
        end
        for (int d = 0; d < 2; d++) begin exp_q[d].delete(); obs_q[d].delete(); end
    endtask

    task automatic test_freeze_clear();
        bus_cycle(1, 0, 1, 4'd5, 32'h3, 4'b1110);
        bus_cycle(1, 1, 0, 4'd2, 0, 0);
        bus_cycle(1, 0, 1, 4'd5, 32'h2, 4'b0001);
        bus_cycle(1, 1, 0, 4'd2, 0, 0);
        idle(20);
        bus_cycle(1, 1, 0, 4'd2, 0, 0);
        bus_cycle(1, 1, 0, 4'd5, 0, 0);
        bus_cycle(1, 0, 1, 4'd5, 32'h1, 4'b0001);
        bus_cycle(1, 1, 0, 4'd2, 0, 0);
        bus_cycle(1, 1, 0, 4'd5, 0, 0);
        bus_cycle(1, 1, 0, 4'd2, 0, 0);
        idle(5);
        for (int d = 0; d < 2; d++) begin
            compared++;
            if (obs_q[d].size() != exp_q[d].size()) begin
                failed++;
                $display("FAIL frz_count dut%0d got %0d want %0d", d, obs_q[d].size(), exp_q[d].size());
            end
            for (int i = 0; i < exp_q[d].size() && i < obs_q[d].size(); i++) begin
                compared++;
                if (obs_q[d][i] !== exp_q[d][i]) begin
                    failed++;
                    $display("FAIL frz_resp dut%0d #%0d got %h@%0d want %h@%0d", d, i,
                             obs_q[d][i].data, obs_q[d][i].cyc, exp_q[d][i].data, exp_q[d][i].cyc);
                end
            end
        end
        compared++;
        if (obs_q[0].size() < 6 || obs_q[0][1].data !== obs_q[0][2].data
            || obs_q[0][4].data > 32'd1) begin
            failed++;
            $display("FAIL frz_hold got %h/%h after_clear=%h want equal and <=1",
                     obs_q[0].size() > 1 ? obs_q[0][1].data : 32'hx,
                     obs_q[0].size() > 2 ? obs_q[0][2].data : 32'hx,
                     obs_q[0].size() > 4 ? obs_q[0][4].data : 32'hx);
        end
        for (int d = 0; d < 2; d++) begin exp_q[d].delete(); obs_q[d].delete(); end
    endtask

    task automatic test_user_words();
        bus_cycle(1, 1, 0, 4'd8, 0, 0);
        bus_cycle(1, 1, 0, 4'd10, 0, 0);
        bus_cycle(1, 1, 0, 4'd11, 0, 0);
        bus_cycle(1, 1, 0, 4'd9, 0, 0);
        bus_cycle(1, 1, 0, 4'd15, 0, 0);
        idle(5);
        for (int d = 0; d < 2; d++) begin
            compared++;
            if (obs_q[d].size() != exp_q[d].size()) begin
                failed++;
                $display("FAIL user_count dut%0d got %0d want %0d", d, obs_q[d].size(), exp_q[d].size());
            end
            for (int i = 0; i < exp_q[d].size() && i < obs_q[d].size(); i++) begin
                compared++;
                if (obs_q[d][i] !== exp_q[d][i]) begin
                    failed++;
                    $display("FAIL user_resp dut%0d #%0d got %h@%0d want %h@%0d", d, i,
                             obs_q[d][i].data, obs_q[d][i].cyc, exp_q[d][i].data, exp_q[d][i].cyc);
                end
            end
        end
        compared++;
        if (obs_q[0].size() < 3 || obs_q[0][0].data !== 32'hA5A5_0000
            || obs_q[0][1].data !== 32'h2222_0002 || obs_q[0][2].data !== 32'h0) begin
            failed++;
            $display("FAIL user_words got %h/%h/%h want A5A50000/22220002/0",
                     obs_q[0].size() > 0 ? obs_q[0][0].data : 32'hx,
                     obs_q[0].size() > 1 ? obs_q[0][1].data : 32'hx,
                     obs_q[0].size() > 2 ? obs_q[0][2].data : 32'hx);
        end
        for (int d = 0; d < 2; d++) begin exp_q[d].delete(); obs_q[d].delete(); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 15));
            bus_cycle(($urandom % 4) != 0, $urandom % 2 == 1, $urandom % 2 == 1,
                      a, $urandom, 4'($urandom));
        end
        idle(5);
        for (int d = 0; d < 2; d++) begin
            compared++;
            if (obs_q[d].size() != exp_q[d].size()) begin
                failed++;
                $display("FAIL rand_count dut%0d got %0d want %0d", d, obs_q[d].size(), exp_q[d].size());
            end
            for (int i = 0; i < exp_q[d].size() && i < obs_q[d].size(); i++) begin
                compared++;
                if (obs_q[d][i] !== exp_q[d][i]) begin
                    failed++;
                    $display("FAIL rand_resp dut%0d #%0d got %h@%0d want %h@%0d", d, i,
                             obs_q[d][i].data, obs_q[d][i].cyc, exp_q[d][i].data, exp_q[d][i].cyc);
                end
            end
        end
        compared++;
        if (stray != 0) begin
            failed++;
            $display("FAIL idle_data_zero got %0d nonzero idle beats want 0", stray);
        end
        for (int d = 0; d < 2; d++) begin exp_q[d].delete(); obs_q[d].delete(); end
    endtask

    task automatic test_reset_flush();
        bus_cycle(1, 0, 1, 4'd4, 32'h1234_5678, 4'hF);
        bus_cycle(1, 0, 1, 4'd5, 32'h2, 4'h1);
        bus_cycle(1, 1, 0, 4'd4, 0, 0);
        bus_cycle(1, 1, 0, 4'd0, 0, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        chipselect = 0; read = 0; write = 0;
        model_reset();
        for (int d = 0; d < 2; d++) begin exp_q[d].delete(); obs_q[d].delete(); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            compared++;
            if (rvalid[d] !== 1'b0 || rdata[d] !== 32'h0) begin
                failed++;
                $display("FAIL flush_in_reset dut%0d got %b/%h want 0/0", d, rvalid[d], rdata[d]);
            end
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_step();
        idle(6);
        for (int d = 0; d < 2; d++) begin
            compared++;
            if (obs_q[d].size() != 0) begin
                failed++;
                $display("FAIL flush_no_valid dut%0d got %0d beats want 0", d, obs_q[d].size());
            end
            obs_q[d].delete();
        end
        bus_cycle(1, 1, 0, 4'd4, 0, 0);
        bus_cycle(1, 1, 0, 4'd5, 0, 0);
        bus_cycle(1, 1, 0, 4'd3, 0, 0);
        bus_cycle(1, 1, 0, 4'd2, 0, 0);
        idle(5);
        for (int d = 0; d < 2; d++) begin
            compared++;
            if (obs_q[d].size() != exp_q[d].size()) begin
                failed++;
                $display("FAIL flush_count dut%0d got %0d want %0d", d, obs_q[d].size(), exp_q[d].size());
            end
            for (int i = 0; i < exp_q[d].size() && i < obs_q[d].size(); i++) begin
                compared++;
                if (obs_q[d][i] !== exp_q[d][i]) begin
                    failed++;
                    $display("FAIL flush_resp dut%0d #%0d got %h@%0d want %h@%0d", d, i,
                             obs_q[d][i].data, obs_q[d][i].cyc, exp_q[d][i].data, exp_q[d][i].cyc);
                end
            end
        end
        for (int d = 0; d < 2; d++) begin exp_q[d].delete(); obs_q[d].delete(); end
    endtask

    initial begin
        compared = 0;
        failed   = 0;
        stray    = 0;
        test_reset();
        test_id_back_to_back();
        test_scratch();
        test_uptime_snapshot();
        test_freeze_clear();
        test_user_words();
        test_random();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
